// File: rtl/ad_frame_buffer.sv
// ad_frame_buffer: captures one FRAME_LEN frame of AD7606 samples, then streams it to the FFT sink.
// Optional feature: define AD_FRAME_AVG2_EN to store the average of each sample pair (decimation by 2).
module ad_frame_buffer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 1024,
    parameter int AW        = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] ad_data_in,
    input  logic              ad_valid,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_ready,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       frame_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;
    state_t r_state, w_state_nxt;

    logic signed [DATA_W-1:0] r_mem [FRAME_LEN];
    logic [AW-1:0]            r_wr_addr;
    logic [AW-1:0]            r_rd_addr;
    logic                     r_rd_done;
    logic signed [DATA_W-1:0] r_ram_q_p1;
    logic                     r_vld_p1, r_sop_p1, r_eop_p1;
    logic signed [DATA_W-1:0] r_data_p2;
    logic                     r_vld_p2, r_sop_p2, r_eop_p2;
    logic                     r_overrun;
    logic [15:0]              r_frame_cnt;

    logic signed [DATA_W-1:0] w_ad_data;
    logic signed [DATA_W-1:0] w_wr_data;
    logic                     w_wr_en, w_wr_last, w_adv, w_issue, w_eop_xfer;
    logic                     w_fill_entry, w_stream_entry, w_busy;

    assign w_ad_data = ad_data_in;

`ifdef AD_FRAME_AVG2_EN
    function automatic logic signed [DATA_W-1:0] avg2(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return sum[DATA_W:1];
    endfunction

    logic                     r_avg_phase;
    logic signed [DATA_W-1:0] r_avg_a;

    assign w_wr_en   = (r_state == S_FILL) && ad_valid && r_avg_phase;
    assign w_wr_data = avg2(r_avg_a, w_ad_data);
`else
    assign w_wr_en   = (r_state == S_FILL) && ad_valid;
    assign w_wr_data = w_ad_data;
`endif

    assign w_wr_last  = w_wr_en && (r_wr_addr == LAST_ADDR);
    // The whole read pipeline freezes while a presented beat is not taken.
    assign w_adv      = !r_vld_p2 || src_ready;
    assign w_issue    = (r_state == S_STREAM) && !r_rd_done && w_adv;
    assign w_eop_xfer = r_vld_p2 && src_ready && r_eop_p2;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                w_busy = 1'b1;
                if (w_wr_last) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                w_busy = 1'b1;
                if (w_eop_xfer) w_state_nxt = en ? S_FILL : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fill_entry   = (w_state_nxt == S_FILL) && (r_state != S_FILL);
    assign w_stream_entry = (w_state_nxt == S_STREAM) && (r_state != S_STREAM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_rd_done   <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_sop_p1    <= 1'b0;
            r_eop_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_sop_p2    <= 1'b0;
            r_eop_p2    <= 1'b0;
            r_data_p2   <= '0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
`ifdef AD_FRAME_AVG2_EN
            r_avg_phase <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;

            // Stage p0: write side and overrun tracking
            if (w_fill_entry) begin
                r_wr_addr <= '0;
                r_overrun <= 1'b0;
`ifdef AD_FRAME_AVG2_EN
                r_avg_phase <= 1'b0;
`endif
            end else begin
                if (w_wr_en) r_wr_addr <= r_wr_addr + AW'(1);
                if ((r_state == S_STREAM) && ad_valid) r_overrun <= 1'b1;
`ifdef AD_FRAME_AVG2_EN
                if ((r_state == S_FILL) && ad_valid) r_avg_phase <= !r_avg_phase;
`endif
            end

            if (w_stream_entry) begin
                r_rd_addr <= '0;
                r_rd_done <= 1'b0;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + AW'(1);
                if (r_rd_addr == LAST_ADDR) r_rd_done <= 1'b1;
            end

            // Stage p1: RAM read data and frame markers
            if (w_adv) begin
                r_vld_p1 <= w_issue;
                r_sop_p1 <= w_issue && (r_rd_addr == '0);
                r_eop_p1 <= w_issue && (r_rd_addr == LAST_ADDR);
            end

            // Stage p2: output beat register
            if (w_adv) begin
                r_vld_p2 <= r_vld_p1;
                r_sop_p2 <= r_sop_p1;
                r_eop_p2 <= r_eop_p1;
                if (r_vld_p1) r_data_p2 <= r_ram_q_p1;
            end

            if (w_eop_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_addr] <= w_wr_data;
        if (w_issue) r_ram_q_p1 <= r_mem[r_rd_addr];
    end

`ifdef AD_FRAME_AVG2_EN
    always_ff @(posedge clk) begin
        if ((r_state == S_FILL) && ad_valid && !r_avg_phase) r_avg_a <= w_ad_data;
    end
`endif

    assign src_data  = r_data_p2;
    assign src_valid = r_vld_p2;
    assign src_sop   = r_sop_p2;
    assign src_eop   = r_eop_p2;
    assign busy      = w_busy;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_ad_frame_buffer.sv
// Directed bench for ad_frame_buffer with FRAME_LEN=8: capture, streaming, stalls, overrun, reset, en drop.
// With AD_FRAME_AVG2_EN defined every stored sample is fed as a pair and a pair-average frame is added.
module tb_ad_frame_buffer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] ad_data_in;
    logic        ad_valid;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic        src_ready;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] in_a  [8];
    logic [15:0] in_b  [8];
    logic [15:0] exp_v [8];

    ad_frame_buffer #(.DATA_W(16), .FRAME_LEN(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ad_data_in (ad_data_in),
        .ad_valid   (ad_valid),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_sop    (src_sop),
        .src_eop    (src_eop),
        .src_ready  (src_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [15:0] v);
        ad_valid   = 1'b1;
        ad_data_in = v;
        tick();
        ad_valid   = 1'b0;
    endtask

    task automatic load_ramp(input int base);
        for (int i = 0; i < 8; i++) begin
            in_a[i]  = 16'(base + i);
            in_b[i]  = 16'(base + i);
            exp_v[i] = 16'(base + i);
        end
    endtask

    // One strobe every 4 cycles; ends one cycle after the last stored sample.
    task automatic fill();
        for (int i = 0; i < 8; i++) begin
`ifdef AD_FRAME_AVG2_EN
            strobe(in_a[i]);
            gap(3);
            strobe(in_b[i]);
`else
            strobe(in_a[i]);
`endif
            if (i < 7) gap(3);
        end
    endtask

    task automatic collect(input bit toggle, output int first_c, output int last_c);
        int          k;
        int          beat;
        bit          done;
        bit          prev_stall;
        logic [15:0] pd;
        logic        ps, pe;
        k = 0; beat = 0; done = 1'b0; prev_stall = 1'b0;
        pd = '0; ps = 1'b0; pe = 1'b0;
        first_c = -1; last_c = -1;
        while (!done && k < 100) begin
            src_ready = toggle ? (k % 2 == 0) : 1'b1;
            if (prev_stall) begin
                chk("stall_valid", 32'(src_valid), 32'd1);
                chk("stall_data", 32'(src_data), 32'(pd));
                chk("stall_sop", 32'(src_sop), 32'(ps));
                chk("stall_eop", 32'(src_eop), 32'(pe));
            end
            if (src_valid && src_ready) begin
                chk("beat_data", 32'(src_data), 32'(exp_v[beat]));
                chk("beat_sop", 32'(src_sop), 32'(beat == 0));
                chk("beat_eop", 32'(src_eop), 32'(beat == 7));
                if (beat == 0) first_c = k;
                last_c = k;
                if (src_eop || beat == 7) done = 1'b1;
                beat++;
            end
            prev_stall = src_valid && !src_ready;
            pd = src_data; ps = src_sop; pe = src_eop;
            tick();
            k++;
        end
        src_ready = 1'b1;
        chk("collect_done", 32'(done), 32'd1);
        chk("beat_count", 32'(beat), 32'd8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, lc;
        rst_n = 1'b0; en = 1'b0; ad_valid = 1'b0; ad_data_in = '0; src_ready = 1'b1;
        gap(2);
        chk("rst_valid", 32'(src_valid), 32'd0);
        chk("rst_sop", 32'(src_sop), 32'd0);
        chk("rst_eop", 32'(src_eop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_data", 32'(src_data), 32'd0);

        // Frame 1: ramp 0..7, sink always ready
        rst_n = 1'b1; en = 1'b1;
        tick();
        chk("fill_busy", 32'(busy), 32'd1);
        load_ramp(0);
        fill();
        collect(1'b0, fc, lc);
        chk("f1_first_latency", 32'(fc), 32'd2);
        chk("f1_consecutive", 32'(lc - fc), 32'd7);
        chk("f1_valid_drop", 32'(src_valid), 32'd0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_busy_fill", 32'(busy), 32'd1);

        // Frame 2: same ramp, sink ready toggling every cycle
        fill();
        collect(1'b1, fc, lc);
        chk("f2_span", 32'(lc - fc), 32'd14);
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Frame 3: three strobes while streaming are dropped and flagged
        load_ramp(10);
        fill();
        src_ready = 1'b0;
        strobe(16'hDEAD);
        chk("ovr_set", 32'(overrun), 32'd1);
        gap(2);
        strobe(16'hBEEF);
        gap(2);
        strobe(16'hCAFE);
        chk("ovr_held", 32'(overrun), 32'd1);
        chk("ovr_busy", 32'(busy), 32'd1);
        collect(1'b0, fc, lc);
        chk("ovr_clear_on_fill", 32'(overrun), 32'd0);
        chk("f3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Frame 4: holds only post-stream samples; en drops mid-stream
        load_ramp(20);
        fill();
        en = 1'b0;
        collect(1'b0, fc, lc);
        chk("f4_idle_busy", 32'(busy), 32'd0);
        chk("f4_frame_cnt", 32'(frame_cnt), 32'd4);
        strobe(16'h1234);
        gap(3);
        strobe(16'h5678);
        gap(3);
        chk("idle_stays", 32'(busy), 32'd0);
        chk("idle_no_ovr", 32'(overrun), 32'd0);
        chk("idle_no_valid", 32'(src_valid), 32'd0);

        // Reset after 5 samples of FILL abandons the frame
        en = 1'b1;
        tick();
        load_ramp(30);
        for (int i = 0; i < 5; i++) begin
            strobe(in_a[i]);
            gap(3);
        end
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(src_valid), 32'd0);
        chk("mid_rst_sop", 32'(src_sop), 32'd0);
        chk("mid_rst_eop", 32'(src_eop), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_data", 32'(src_data), 32'd0);
        rst_n = 1'b1;
        tick();
        load_ramp(40);
        fill();
        collect(1'b0, fc, lc);
        chk("post_rst_latency", 32'(fc), 32'd2);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef AD_FRAME_AVG2_EN
        // Pair averaging: (100,-101)->-1, (7FFF,7FFF)->7FFF, (8000,8000)->8000
        load_ramp(50);
        in_a[0] = 16'd100;   in_b[0] = 16'hFF9B; exp_v[0] = 16'hFFFF;
        in_a[1] = 16'h7FFF;  in_b[1] = 16'h7FFF; exp_v[1] = 16'h7FFF;
        in_a[2] = 16'h8000;  in_b[2] = 16'h8000; exp_v[2] = 16'h8000;
        fill();
        collect(1'b0, fc, lc);
        chk("avg_frame_cnt", 32'(frame_cnt), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
